// File: rtl/riscv_hazard_ctrl_if.sv
// Hazard-controller port bundle: ID-stage operand/destination info and EX branch resolution in;
// stall/bubble/flush, EX forward selects and perf counters out.
interface riscv_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_RegWrite;
    logic              id_MemRead;
    logic              ex_branch_taken;

    logic              pc_stall;
    logic              ifid_stall;
    logic              idex_bubble;
    logic              flush;
    logic [1:0]        fwdA;
    logic [1:0]        fwdB;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_RegWrite, id_MemRead, ex_branch_taken,
        input  pc_stall, ifid_stall, idex_bubble, flush, fwdA, fwdB,
               stall_cnt, flush_cnt, retire_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_RegWrite, id_MemRead, ex_branch_taken,
        output pc_stall, ifid_stall, idex_bubble, flush, fwdA, fwdB,
               stall_cnt, flush_cnt, retire_cnt
    );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core; define HAZARD_PERF_EN for saturating perf counters.
// Outputs are combinational from tracker/FSM state plus ID inputs; the block issues stalls and receives none.
module riscv_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset,
    riscv_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, FLUSH = 2'd2} state_t;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } slot_t;

    localparam int LL_INIT = (LOAD_LATENCY > 1) ? LOAD_LATENCY - 2 : 0;
    localparam int FL_INIT = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    slot_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;

    logic       branch, load_use;
    logic       stall_now, flush_now, flush_entry;
    logic [1:0] fwd_a, fwd_b;

    assign branch   = ex_q.vld && hz.ex_branch_taken;
    assign load_use = ex_q.vld && ex_q.mem_read && (ex_q.rd != '0) && hz.id_valid &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == ex_q.rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == ex_q.rd)));

    // A taken branch wins over load-use: the stalled ID instruction is wrong-path anyway.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_now   = 1'b0;
        flush_now   = 1'b0;
        flush_entry = 1'b0;
        case (state_q)
            RUN: begin
                if (branch) begin
                    flush_now   = 1'b1;
                    flush_entry = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = 3'(FL_INIT);
                    end
                end else if (load_use) begin
                    stall_now = 1'b1;
                    if (LOAD_LATENCY > 1) begin
                        state_d = LSTALL;
                        cnt_d   = 3'(LL_INIT);
                    end
                end
            end
            LSTALL: begin
                stall_now = 1'b1;
                if (cnt_q == 3'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 3'd1;
            end
            FLUSH: begin
                flush_now = 1'b1;
                if (cnt_q == 3'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Invalid EX slots also clear their source fields so they can never match a forward.
    always_comb begin
        wb_d     = mem_q;
        mem_d    = ex_q;
        ex_d     = '0;
        ex_rs1_d = '0;
        ex_rs2_d = '0;
        if (hz.id_valid && !stall_now && !flush_now) begin
            ex_d     = '{vld: 1'b1, rd: hz.id_rd, reg_write: hz.id_RegWrite, mem_read: hz.id_MemRead};
            ex_rs1_d = hz.id_rs1;
            ex_rs2_d = hz.id_rs2;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input slot_t mem, input slot_t wb);
        if (mem.vld && mem.reg_write && !mem.mem_read && (mem.rd != '0) && (mem.rd == rs)) return 2'b10;
        if (wb.vld && wb.reg_write && (wb.rd != '0) && (wb.rd == rs))                      return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs1_q, mem_q, wb_q);
        fwd_b = fwd_sel(ex_rs2_q, mem_q, wb_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            cnt_q    <= 3'd0;
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
        end
    end

    assign hz.pc_stall    = stall_now;
    assign hz.ifid_stall  = stall_now;
    assign hz.idex_bubble = stall_now;
    assign hz.flush       = flush_now;
    assign hz.fwdA        = fwd_a;
    assign hz.fwdB        = fwd_b;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (stall_now && (stall_cnt_q != '1))    stall_cnt_d  = stall_cnt_q + CNT_W'(1);
        if (flush_entry && (flush_cnt_q != '1))  flush_cnt_d  = flush_cnt_q + CNT_W'(1);
        if (wb_q.vld && (retire_cnt_q != '1))    retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;
    assign hz.retire_cnt = retire_cnt_q;
`else
    assign hz.stall_cnt  = '0;
    assign hz.flush_cnt  = '0;
    assign hz.retire_cnt = '0;
`endif
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl: two instances (load latency 1 / flush 2 and load latency 3 / flush 3)
// share one stimulus stream and are compared against an instruction-level pipeline model.
module tb_riscv_hazard_ctrl;
    localparam int LL0 = 1, FC0 = 2, LL1 = 3, FC1 = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_RegWrite, id_MemRead, br;
    logic [4:0] id_rs1, id_rs2, id_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ifa ();
    riscv_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ifb ();

    riscv_hazard_ctrl #(.REG_AW(5), .LOAD_LATENCY(LL0), .FLUSH_CYCLES(FC0), .CNT_W(32))
        dut_a (.clk(clk), .reset(reset), .hz(ifa));
    riscv_hazard_ctrl #(.REG_AW(5), .LOAD_LATENCY(LL1), .FLUSH_CYCLES(FC1), .CNT_W(32))
        dut_b (.clk(clk), .reset(reset), .hz(ifb));

    assign ifa.id_valid = id_valid;       assign ifb.id_valid = id_valid;
    assign ifa.id_rs1 = id_rs1;           assign ifb.id_rs1 = id_rs1;
    assign ifa.id_rs2 = id_rs2;           assign ifb.id_rs2 = id_rs2;
    assign ifa.id_use_rs1 = id_use_rs1;   assign ifb.id_use_rs1 = id_use_rs1;
    assign ifa.id_use_rs2 = id_use_rs2;   assign ifb.id_use_rs2 = id_use_rs2;
    assign ifa.id_rd = id_rd;             assign ifb.id_rd = id_rd;
    assign ifa.id_RegWrite = id_RegWrite; assign ifb.id_RegWrite = id_RegWrite;
    assign ifa.id_MemRead = id_MemRead;   assign ifb.id_MemRead = id_MemRead;
    assign ifa.ex_branch_taken = br;      assign ifb.ex_branch_taken = br;

    // Per-instance outputs packed as {pc_stall, ifid_stall, idex_bubble, flush, fwdA, fwdB}
    logic [7:0]  o_ctl[2];
    logic [95:0] o_cnt[2];
    assign o_ctl[0] = {ifa.pc_stall, ifa.ifid_stall, ifa.idex_bubble, ifa.flush, ifa.fwdA, ifa.fwdB};
    assign o_ctl[1] = {ifb.pc_stall, ifb.ifid_stall, ifb.idex_bubble, ifb.flush, ifb.fwdA, ifb.fwdB};
    assign o_cnt[0] = {ifa.stall_cnt, ifa.flush_cnt, ifa.retire_cnt};
    assign o_cnt[1] = {ifb.stall_cnt, ifb.flush_cnt, ifb.retire_cnt};

    // Reference model: instructions in EX/MEM/WB plus "cycles still owed" for stall and flush
    typedef struct {bit v; int rd; bit rw; bit mr; int rs1; int rs2;} mslot_t;
    mslot_t m_ex[2], m_mem[2], m_wb[2];
    int     st_left[2], fl_left[2];
    longint n_stall[2], n_flush[2], n_ret[2];
    bit     e_stall[2], e_fl[2], e_entry[2];
    int     e_fa[2], e_fb[2];
    int     ll_p[2] = '{LL0, LL1};
    int     fc_p[2] = '{FC0, FC1};

    function automatic int fwd_of(int k, int r);
        if (m_mem[k].v && m_mem[k].rw && !m_mem[k].mr && m_mem[k].rd != 0 && m_mem[k].rd == r) return 2;
        if (m_wb[k].v && m_wb[k].rw && m_wb[k].rd != 0 && m_wb[k].rd == r) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] exp_cnt(longint n);
`ifdef HAZARD_PERF_EN
        return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            bit hit;
            hit = m_ex[k].v && m_ex[k].mr && m_ex[k].rd != 0 && id_valid &&
                  ((id_use_rs1 && int'(id_rs1) == m_ex[k].rd) || (id_use_rs2 && int'(id_rs2) == m_ex[k].rd));
            e_stall[k] = 0; e_fl[k] = 0; e_entry[k] = 0;
            if (fl_left[k] > 0)             e_fl[k] = 1;
            else if (st_left[k] > 0)        e_stall[k] = 1;
            else if (m_ex[k].v && br) begin e_fl[k] = 1; e_entry[k] = 1; end
            else if (hit)                   e_stall[k] = 1;
            e_fa[k] = fwd_of(k, m_ex[k].rs1);
            e_fb[k] = fwd_of(k, m_ex[k].rs2);
        end
    endtask

    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_ex[k] = '{default: 0}; m_mem[k] = '{default: 0}; m_wb[k] = '{default: 0};
                st_left[k] = 0; fl_left[k] = 0;
                n_stall[k] = 0; n_flush[k] = 0; n_ret[k] = 0;
            end else begin
                if (fl_left[k] > 0)      fl_left[k]--;
                else if (st_left[k] > 0) st_left[k]--;
                else if (e_entry[k])     fl_left[k] = fc_p[k] - 1;
                else if (e_stall[k])     st_left[k] = ll_p[k] - 1;
                n_stall[k] += e_stall[k];
                n_flush[k] += e_entry[k];
                n_ret[k]   += m_wb[k].v;
                m_wb[k]  = m_mem[k];
                m_mem[k] = m_ex[k];
                if (id_valid && !e_stall[k] && !e_fl[k])
                    m_ex[k] = '{1'b1, int'(id_rd), id_RegWrite, id_MemRead, int'(id_rs1), int'(id_rs2)};
                else
                    m_ex[k] = '{default: 0};
            end
        end
    endtask

    // Inputs change at the falling edge; outputs settle and are sampled 1 time unit later.
    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_commit();
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int rd, input int rs1, input int rs2,
                          input bit u1, input bit u2, input bit rw, input bit mr);
        id_valid = v; id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2; id_RegWrite = rw; id_MemRead = mr;
    endtask

    task automatic do_reset();
        reset = 1'b1; br = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        settle(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; br = 1'b1;
        set_id(1, 5, 5, 5, 1, 1, 1, 1);
        settle(); tick();
        reset = 1'b0; br = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({o_ctl[k], o_cnt[k]} !== 104'h0) begin
                errors++;
                $display("FAIL reset_outputs[%0d] got ctl=%h cnt=%h want all zero", k, o_ctl[k], o_cnt[k]);
            end
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 5, 1, 0, 1, 0, 1, 1);              // lw x5, 0(x1)
        settle(); tick();
        set_id(1, 6, 5, 7, 1, 1, 1, 0);              // add x6, x5, x7
        settle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_ctl[k][7:4] !== 4'b1110) begin
                errors++;
                $display("FAIL loaduse_stall[%0d] got %b want 1110", k, o_ctl[k][7:4]);
            end
        end
        tick(); settle();
        checks++;
        if (o_ctl[0][7:4] !== 4'b0000) begin
            errors++;
            $display("FAIL loaduse_release got %b want 0000", o_ctl[0][7:4]);
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (o_ctl[0][3:0] !== 4'b0100) begin
            errors++;
            $display("FAIL loaduse_fwd got fwdA/fwdB=%b want 0100", o_ctl[0][3:0]);
        end
        tick();
    endtask

    task automatic test_forward();
        do_reset();
        set_id(1, 3, 1, 2, 1, 1, 1, 0); settle(); tick();   // add x3 (to WB)
        set_id(1, 3, 1, 2, 1, 1, 1, 0); settle(); tick();   // add x3 (to MEM)
        set_id(1, 4, 3, 3, 1, 1, 1, 0); settle(); tick();   // sub x4, x3, x3
        set_id(0, 0, 0, 0, 0, 0, 0, 0); settle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_ctl[k][3:0] !== 4'b1010) begin
                errors++;
                $display("FAIL fwd_mem_prio[%0d] got %b want 1010", k, o_ctl[k][3:0]);
            end
        end
        tick();
        do_reset();
        set_id(1, 3, 1, 2, 1, 1, 1, 0); settle(); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); settle(); tick();
        set_id(1, 4, 3, 3, 1, 1, 1, 0); settle(); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); settle();
        checks++;
        if (o_ctl[0][3:0] !== 4'b0101) begin
            errors++;
            $display("FAIL fwd_wb got %b want 0101", o_ctl[0][3:0]);
        end
        tick();
    endtask

    task automatic test_branch();
        logic [31:0] want_fc;
        do_reset();
        set_id(1, 0, 1, 2, 1, 1, 0, 0); settle(); tick();   // beq into EX
        br = 1'b1;
        set_id(1, 9, 1, 2, 1, 1, 1, 0);
        settle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_ctl[k][7:4] !== 4'b0001) begin
                errors++;
                $display("FAIL branch_c1[%0d] got %b want 0001", k, o_ctl[k][7:4]);
            end
        end
        tick(); settle();
        checks++;
        if ({o_ctl[0][4], o_ctl[1][4]} !== 2'b11) begin
            errors++;
            $display("FAIL branch_c2 got flush a/b=%b want 11", {o_ctl[0][4], o_ctl[1][4]});
        end
        tick(); settle();
        checks++;
        if ({o_ctl[0][4], o_ctl[1][4]} !== 2'b01) begin
            errors++;
            $display("FAIL branch_c3 got flush a/b=%b want 01", {o_ctl[0][4], o_ctl[1][4]});
        end
        tick();
        br = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
`ifdef HAZARD_PERF_EN
        want_fc = 32'd1;
`else
        want_fc = 32'd0;
`endif
        checks++;
        if (o_cnt[0][63:32] !== want_fc) begin
            errors++;
            $display("FAIL branch_flush_cnt got %0d want %0d", o_cnt[0][63:32], want_fc);
        end
        tick();
    endtask

    task automatic test_branch_vs_loaduse();
        do_reset();
        set_id(1, 5, 1, 0, 1, 0, 1, 1); settle(); tick();   // lw x5
        br = 1'b1;
        set_id(1, 6, 5, 7, 1, 1, 1, 0);
        settle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_ctl[k][7:4] !== 4'b0001) begin
                errors++;
                $display("FAIL br_vs_lu[%0d] got %b want 0001", k, o_ctl[k][7:4]);
            end
        end
        tick();
        br = 1'b0;
        settle();
        checks++;
        if (o_ctl[0][7:4] !== 4'b0001) begin
            errors++;
            $display("FAIL br_vs_lu_c2 got %b want 0001", o_ctl[0][7:4]);
        end
        tick(); settle();
        checks++;
        if (o_ctl[0][7:4] !== 4'b0000) begin
            errors++;
            $display("FAIL br_vs_lu_nostall got %b want 0000", o_ctl[0][7:4]);
        end
        tick();
    endtask

    task automatic test_lstall_reset();
        do_reset();
        set_id(1, 5, 1, 0, 1, 0, 1, 1); settle(); tick();
        set_id(1, 6, 5, 7, 1, 0, 1, 0);
        settle();
        checks++;
        if (o_ctl[1][7:4] !== 4'b1110) begin
            errors++;
            $display("FAIL lstall_c1 got %b want 1110", o_ctl[1][7:4]);
        end
        tick(); settle();
        checks++;
        if (o_ctl[1][7:4] !== 4'b1110) begin
            errors++;
            $display("FAIL lstall_c2 got %b want 1110", o_ctl[1][7:4]);
        end
        reset = 1'b1;
        settle(); tick();
        reset = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if ({o_ctl[1], o_cnt[1]} !== 104'h0) begin
            errors++;
            $display("FAIL lstall_reset got ctl=%h cnt=%h want all zero", o_ctl[1], o_cnt[1]);
        end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_id(1, 0, 0, 0, 1, 1, 1, c[0]);
            settle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_ctl[k] !== 8'h00) begin
                    errors++;
                    $display("FAIL x0_cyc%0d[%0d] got %b want 00000000", c, k, o_ctl[k]);
                end
            end
            tick();
        end
        settle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_cnt[k] !== {32'd0, 32'd0, exp_cnt(n_ret[k])}) begin
                errors++;
                $display("FAIL x0_counters[%0d] got %h want %h", k, o_cnt[k], {32'd0, 32'd0, exp_cnt(n_ret[k])});
            end
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            br    = ($urandom_range(0, 5) == 0);
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            settle();
            for (int k = 0; k < 2; k++) begin
                logic [7:0]  want_ctl;
                logic [95:0] want_cnt;
                want_ctl = {e_stall[k], e_stall[k], e_stall[k], e_fl[k], 2'(e_fa[k]), 2'(e_fb[k])};
                want_cnt = {exp_cnt(n_stall[k]), exp_cnt(n_flush[k]), exp_cnt(n_ret[k])};
                checks++;
                if (o_ctl[k] !== want_ctl) begin
                    errors++;
                    $display("FAIL rand_ctl[%0d] cyc %0d got %b want %b", k, c, o_ctl[k], want_ctl);
                end
                checks++;
                if (o_cnt[k] !== want_cnt) begin
                    errors++;
                    $display("FAIL rand_cnt[%0d] cyc %0d got %h want %h", k, c, o_cnt[k], want_cnt);
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; br = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '{default: 0}; m_mem[k] = '{default: 0}; m_wb[k] = '{default: 0};
            st_left[k] = 0; fl_left[k] = 0; n_stall[k] = 0; n_flush[k] = 0; n_ret[k] = 0;
        end
        @(negedge clk);
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_branch_vs_loaduse();
        test_lstall_reset();
        test_x0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
